// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: word/register types, writeback source select,
// and the memory-stage FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    WRITE_ALU = 2'd0,
    WRITE_RAM = 2'd1,
    WRITE_NPC = 2'd2
  } wdat_source_t;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } memstate_t;

  // Reservations are tracked at word granularity
  function automatic logic addr_match(input word_t a, input word_t b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/link_reg.sv
// Load-linked reservation register; only instantiated by mem_stage when LLSC_EN is defined.
// Holds valid + address, set by a completed LL, cleared by snoop invalidates or local stores.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set,
  input  word_t set_addr,
  input  logic  store,
  input  word_t store_addr,
  input  logic  inv,
  input  word_t inv_addr,
  input  word_t chk_addr,
  output logic  match
);

  logic  link_valid;
  word_t link_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      // A snoop hitting the line in the same cycle as the LL leaves no reservation
      link_valid <= !(inv && addr_match(inv_addr, set_addr));
      link_addr  <= set_addr;
    end else if ((store && addr_match(store_addr, link_addr)) ||
                 (inv && addr_match(inv_addr, link_addr))) begin
      link_valid <= 1'b0;
    end
  end

  assign match = link_valid && addr_match(chk_addr, link_addr);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-cache requests, freezes completed accesses while the pipeline is
// stalled, and owns the MEM/WB register. Optional LL/SC support is enabled by `define LLSC_EN.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   mem_valid,
  input  logic                   mem_ren,
  input  logic                   mem_wen,
  input  logic                   mem_ll,
  input  logic                   mem_sc,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_store,
  input  logic [4:0]             mem_wsel,
  input  logic [1:0]             mem_wdat_source,
  input  logic [31:0]            mem_instr_npc,
  input  logic                   mem_halt,
  input  logic                   mem_advance,
  input  logic                   dhit,
  input  logic [31:0]            dload,
  input  logic                   ccinv,
  input  logic [31:0]            ccsnoopaddr,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [31:0]            dmemaddr,
  output logic [31:0]            dmemstore,
  output logic                   data_stall,
  output logic [31:0]            dmemload,
  output logic                   wb_valid,
  output logic [4:0]             wb_wsel,
  output logic [1:0]             wb_wdat_source,
  output logic [31:0]            wb_alu_result,
  output logic [31:0]            wb_dmemload,
  output logic [31:0]            wb_instr_npc,
  output logic                   wb_halt,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  memstate_t state;
  word_t     hold_data;
  logic      hold_sc;
  logic      idle;
  logic      sc_op;
  logic      sc_ok;
  logic      sc_res;
  logic      wr_ok;
  logic      need;
  logic      access_done;

  assign idle  = (state == IDLE);
  assign sc_op = mem_wen & mem_sc;

`ifdef LLSC_EN
  logic link_match;

  link_reg u_link_reg (
    .clk        (CLK),
    .rst        (nRST),
    .set        (access_done & mem_ren & mem_ll),
    .set_addr   (mem_addr),
    .store      (access_done & mem_wen),
    .store_addr (mem_addr),
    .inv        (ccinv),
    .inv_addr   (ccsnoopaddr),
    .chk_addr   (mem_addr),
    .match      (link_match)
  );

  assign sc_ok = link_match;
`else
  logic unused_llsc;

  assign unused_llsc = ^{mem_ll, ccinv, ccsnoopaddr};
  assign sc_ok       = 1'b1;
`endif

  // A failed SC never reaches the cache, so it cannot stall
  assign wr_ok       = mem_wen & (!mem_sc | sc_ok);
  assign need        = mem_valid & (mem_ren | wr_ok);
  assign access_done = need & idle & dhit;

  assign dmemREN    = need & mem_ren & idle;
  assign dmemWEN    = need & wr_ok & idle;
  assign dmemaddr   = mem_addr;
  assign dmemstore  = mem_store;
  assign data_stall = need & idle & !dhit;
  assign dmemload   = idle ? dload : hold_data;

  // The reservation may already be gone once frozen in DONE, so use the captured result
  assign sc_res = idle ? sc_ok : hold_sc;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_done && !mem_advance) begin
            state     <= DONE;
            hold_data <= dload;
            hold_sc   <= sc_ok;
          end
        end
        DONE: begin
          if (mem_advance) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      stall_cycles <= '0;
    end else if (data_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      wb_valid       <= 1'b0;
      wb_wsel        <= '0;
      wb_wdat_source <= '0;
      wb_alu_result  <= '0;
      wb_dmemload    <= '0;
      wb_instr_npc   <= '0;
      wb_halt        <= 1'b0;
    end else if (data_stall) begin
      wb_valid <= 1'b0;
      wb_wsel  <= '0;
    end else if (mem_advance) begin
      wb_valid       <= mem_valid;
      wb_wsel        <= mem_wsel;
      wb_wdat_source <= sc_op ? WRITE_ALU : mem_wdat_source;
      wb_alu_result  <= sc_op ? {31'b0, sc_res} : mem_addr;
      wb_dmemload    <= dmemload;
      wb_instr_npc   <= mem_instr_npc;
      wb_halt        <= mem_halt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions checked
// against a transaction-level model of stall count, request and writeback behaviour.
module tb_mem_stage;

  localparam int unsigned CW = 4;
  localparam int unsigned SAT = (1 << CW) - 1;
  localparam logic [1:0] W_ALU = 2'd0;
  localparam logic [1:0] W_RAM = 2'd1;
  localparam logic [1:0] W_NPC = 2'd2;

  logic CLK = 1'b0;
  logic nRST;
  logic mem_valid, mem_ren, mem_wen, mem_ll, mem_sc, mem_halt, mem_advance;
  logic [31:0] mem_addr, mem_store, mem_instr_npc, dload, ccsnoopaddr;
  logic [4:0] mem_wsel;
  logic [1:0] mem_wdat_source;
  logic dhit, ccinv;
  logic dmemREN, dmemWEN, data_stall, wb_valid, wb_halt;
  logic [31:0] dmemaddr, dmemstore, dmemload, wb_alu_result, wb_dmemload, wb_instr_npc;
  logic [4:0] wb_wsel;
  logic [1:0] wb_wdat_source;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int unsigned exp_stall = 0;
  logic [4:0] last_wsel = '0;

  mem_stage #(.STALL_CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_ll(mem_ll), .mem_sc(mem_sc), .mem_addr(mem_addr), .mem_store(mem_store),
    .mem_wsel(mem_wsel), .mem_wdat_source(mem_wdat_source), .mem_instr_npc(mem_instr_npc),
    .mem_halt(mem_halt), .mem_advance(mem_advance), .dhit(dhit), .dload(dload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .data_stall(data_stall), .dmemload(dmemload),
    .wb_valid(wb_valid), .wb_wsel(wb_wsel), .wb_wdat_source(wb_wdat_source),
    .wb_alu_result(wb_alu_result), .wb_dmemload(wb_dmemload), .wb_instr_npc(wb_instr_npc),
    .wb_halt(wb_halt), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_ren = 0; mem_wen = 0; mem_ll = 0; mem_sc = 0; mem_halt = 0;
    mem_addr = 0; mem_store = 0; mem_wsel = 0; mem_wdat_source = 0; mem_instr_npc = 0;
    mem_advance = 1; dhit = 0; dload = 0; ccinv = 0; ccsnoopaddr = 0;
  endtask

  // One instruction through MEM: w stall cycles, dhit, then 'freeze' frozen cycles.
  task automatic run_txn(input logic ren, input logic wen, input logic ll, input logic sc,
                         input logic [31:0] addr, input logic [4:0] wsel, input logic [1:0] src,
                         input logic [31:0] data, input int w, input int freeze,
                         input string tag);
    logic [31:0] npc, ev_alu;
    logic [1:0]  ev_src;
    logic        halt;
    npc  = $urandom;
    halt = 1'($urandom_range(0, 1));
    mem_valid = 1; mem_ren = ren; mem_wen = wen; mem_ll = ll; mem_sc = sc;
    mem_addr = addr; mem_store = $urandom; mem_wsel = wsel; mem_wdat_source = src;
    mem_instr_npc = npc; mem_halt = halt; mem_advance = 1; dhit = 0; dload = $urandom;
    for (int i = 0; i < w; i++) begin
      #1;
      checks++;
      if (data_stall !== 1'b1 || dmemREN !== ren || dmemWEN !== wen) begin
        errors++;
        $display("FAIL %s stall_req cyc%0d: stall=%b ren=%b wen=%b want 1 %b %b",
                 tag, i, data_stall, dmemREN, dmemWEN, ren, wen);
      end
      step();
      if (exp_stall < SAT) exp_stall++;
      last_wsel = 0;
      checks++;
      if (wb_valid !== 1'b0 || wb_wsel !== 5'd0) begin
        errors++;
        $display("FAIL %s bubble: valid=%b wsel=%0d want 0 0", tag, wb_valid, wb_wsel);
      end
    end
    dhit = 1; dload = data; mem_advance = (freeze == 0);
    #1;
    checks++;
    if (data_stall !== 1'b0 || dmemload !== data || dmemREN !== ren || dmemWEN !== wen) begin
      errors++;
      $display("FAIL %s hit_cycle: stall=%b load=%h ren=%b wen=%b want 0 %h %b %b",
               tag, data_stall, dmemload, dmemREN, dmemWEN, data, ren, wen);
    end
    step();
    if (freeze > 0) begin
      checks++;
      if (wb_wsel !== last_wsel) begin
        errors++;
        $display("FAIL %s wb_hold: wsel=%0d want %0d", tag, wb_wsel, last_wsel);
      end
      dhit = 0; dload = ~data;
      for (int f = 0; f < freeze; f++) begin
        mem_advance = (f == freeze - 1);
        #1;
        checks++;
        if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || data_stall !== 1'b0 || dmemload !== data)
        begin
          errors++;
          $display("FAIL %s frozen cyc%0d: ren=%b wen=%b stall=%b load=%h want 0 0 0 %h",
                   tag, f, dmemREN, dmemWEN, data_stall, dmemload, data);
        end
        step();
      end
    end
    ev_alu = (sc && wen) ? 32'd1 : addr;
    ev_src = (sc && wen) ? W_ALU : src;
    checks++;
    if ({wb_valid, wb_wsel, wb_wdat_source, wb_halt} !== {1'b1, wsel, ev_src, halt}) begin
      errors++;
      $display("FAIL %s wb_ctrl: v=%b wsel=%0d src=%0d halt=%b want 1 %0d %0d %b",
               tag, wb_valid, wb_wsel, wb_wdat_source, wb_halt, wsel, ev_src, halt);
    end
    checks++;
    if (wb_alu_result !== ev_alu || wb_instr_npc !== npc) begin
      errors++;
      $display("FAIL %s wb_alu_npc: alu=%h npc=%h want %h %h",
               tag, wb_alu_result, wb_instr_npc, ev_alu, npc);
    end
    checks++;
    if (wb_dmemload !== data) begin
      errors++;
      $display("FAIL %s wb_dmemload: got %h want %h", tag, wb_dmemload, data);
    end
    checks++;
    if (32'(stall_cycles) !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, exp_stall);
    end
    last_wsel = wsel;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1;
    step();
    step();
    nRST = 0;
    exp_stall = 0;
    last_wsel = 0;
    checks++;
    if ({wb_valid, wb_wsel, wb_wdat_source, wb_alu_result, wb_dmemload, wb_instr_npc, wb_halt}
        !== '0) begin
      errors++;
      $display("FAIL reset_wb: valid=%b wsel=%0d alu=%h load=%h want all 0",
               wb_valid, wb_wsel, wb_alu_result, wb_dmemload);
    end
    checks++;
    if (stall_cycles !== '0 || data_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: stall_cycles=%0d stall=%b want 0 0", stall_cycles, data_stall);
    end
  endtask

  task automatic test_lw_stall();
    run_txn(1, 0, 0, 0, 32'h100, 5'd3, W_RAM, 32'hDEADBEEF, 3, 0, "lw_stall");
  endtask

  task automatic test_sw_zero_wait();
    run_txn(0, 1, 0, 0, 32'h104, 5'd4, W_ALU, 32'h0BADF00D, 0, 0, "sw_zero");
  endtask

  task automatic test_lw_hold();
    run_txn(1, 0, 0, 0, 32'h108, 5'd5, W_RAM, 32'h12345678, 0, 4, "lw_hold");
  endtask

`ifndef LLSC_EN
  task automatic test_sc_plain();
    run_txn(0, 1, 0, 1, 32'h10C, 5'd6, W_NPC, 32'h55AA55AA, 1, 1, "sc_plain");
    run_txn(1, 0, 1, 0, 32'h110, 5'd7, W_RAM, 32'hCAFE0001, 2, 0, "ll_plain");
  endtask
`else
  task automatic test_llsc();
    run_txn(1, 0, 1, 0, 32'h200, 5'd8, W_RAM, 32'h00000042, 0, 0, "ll_a");
    run_txn(0, 1, 0, 1, 32'h200, 5'd9, W_RAM, 32'h00000000, 1, 0, "sc_pass");
    run_txn(1, 0, 1, 0, 32'h200, 5'd8, W_RAM, 32'h00000043, 0, 0, "ll_b");
    ccinv = 1; ccsnoopaddr = 32'h200;
    step();
    ccinv = 0;
    mem_valid = 1; mem_wen = 1; mem_sc = 1; mem_addr = 32'h200; mem_wsel = 5'd9;
    mem_advance = 1; dhit = 0;
    #1;
    checks++;
    if (dmemWEN !== 1'b0 || data_stall !== 1'b0) begin
      errors++;
      $display("FAIL sc_fail_req: wen=%b stall=%b want 0 0", dmemWEN, data_stall);
    end
    step();
    checks++;
    if (wb_alu_result !== 32'd0 || wb_valid !== 1'b1 || wb_wsel !== 5'd9) begin
      errors++;
      $display("FAIL sc_fail_wb: alu=%h valid=%b wsel=%0d want 0 1 9",
               wb_alu_result, wb_valid, wb_wsel);
    end
    last_wsel = 5'd9;
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic op, ll, sc;
      op = 1'($urandom_range(0, 1));
      ll = op & 1'($urandom_range(0, 1));
`ifdef LLSC_EN
      sc = 1'b0;
`else
      sc = !op & 1'($urandom_range(0, 1));
`endif
      run_txn(op, !op, ll, sc, $urandom, 5'($urandom_range(1, 31)),
              2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_done();
    mem_valid = 1; mem_ren = 1; mem_addr = 32'h300; mem_wsel = 5'd10;
    mem_wdat_source = W_RAM; mem_advance = 0; dhit = 1; dload = 32'hA5A5A5A5;
    step();
    dhit = 0;
    #1;
    checks++;
    if (dmemREN !== 1'b0 || dmemload !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL done_state: ren=%b load=%h want 0 a5a5a5a5", dmemREN, dmemload);
    end
    nRST = 1;
    step();
    nRST = 0;
    exp_stall = 0;
    checks++;
    if ({wb_valid, wb_wsel, wb_wdat_source, wb_alu_result, wb_dmemload, wb_instr_npc, wb_halt,
         stall_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b wsel=%0d load=%h cnt=%0d want all 0",
               wb_valid, wb_wsel, wb_dmemload, stall_cycles);
    end
    checks++;
    if (dmemREN !== 1'b1 || data_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_req: ren=%b stall=%b want 1 1", dmemREN, data_stall);
    end
    dhit = 1; mem_advance = 1;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    nRST = 1;
    test_reset();
    test_lw_stall();
    test_sw_zero_wait();
    test_lw_hold();
`ifndef LLSC_EN
    test_sc_plain();
`else
    test_llsc();
`endif
    test_random();
    test_reset_mid_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined datapath. It consumes the EX/MEM latch contents, issues the data-cache request, and produces `data_stall` and the same-cycle `dmemload` used by the forwarding unit. It owns the MEM/WB pipeline register feeding writeback. A small FSM holds completed accesses while the rest of the pipeline is frozen, so a request is never re-issued or lost.

## Interface
Parameters:
- `STALL_CNT_W`, 16: width of the saturating data-stall performance counter.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset. One clock; reset is synchronous and active-high. Asserting `nRST`=1 resets the block; the name is kept for port-list consistency.
- `mem_valid` in 1: EX/MEM latch holds a live instruction.
- `mem_ren`, `mem_wen` in 1 each: load / store.
- `mem_ll`, `mem_sc` in 1 each: load-linked / store-conditional.
- `mem_addr` in 32: effective address (`alu_result`).
- `mem_store` in 32: store data, already forwarded.
- `mem_wsel` in 5: destination register.
- `mem_wdat_source` in 2: `WRITE_RAM` / `WRITE_ALU` / `WRITE_NPC`.
- `mem_instr_npc` in 32: PC+4.
- `mem_halt` in 1: halt.
- `mem_advance` in 1: pipeline may advance; low on any non-data stall.
- `dhit` in 1: cache completes the access.
- `dload` in 32: cache read data.
- `ccinv` in 1: coherence invalidate.
- `ccsnoopaddr` in 32: coherence invalidate address.
- `dmemREN`, `dmemWEN` out 1 each: cache request.
- `dmemaddr`, `dmemstore` out 32 each.
- `data_stall` out 1: access outstanding.
- `dmemload` out 32: load data for the forwarding path.
- `wb_valid`, `wb_wsel`, `wb_wdat_source`, `wb_alu_result`, `wb_dmemload`, `wb_instr_npc`, `wb_halt` out: MEM/WB register contents.
- `stall_cycles` out `STALL_CNT_W`: saturating count of cycles with `data_stall`=1.

## Operation
- `need` = `mem_valid & (mem_ren | mem_wen)`.
- FSM states:
  - IDLE: `dmemREN`/`dmemWEN` = `need`-qualified `mem_ren`/`mem_wen`. On `dhit` with `mem_advance`=0, go to DONE. `dhit` with `mem_advance`=1 stays IDLE. No `dhit` stays IDLE; the request stays asserted.
  - DONE: the access is complete, so no request is asserted. Load data is held in `hold_data`. Exit to IDLE when `mem_advance`=1.
- `data_stall` = `need & (state==IDLE) & !dhit`.
- `dmemload` = `dload` in IDLE, `hold_data` in DONE.
- MEM/WB register:
  - Loads from the latch on the edge where `mem_advance & !data_stall`.
  - `wb_dmemload` takes `dmemload`.
  - When `data_stall`=1, it loads a bubble: `wb_valid`=0, `wb_wsel`=0.
  - When `mem_advance`=0 and `data_stall`=0, it holds.
- `mem_wen` with `mem_sc` is handled per Configuration.
- `stall_cycles` increments each cycle `data_stall`=1 and saturates at all-ones.

## Timing
- Request is combinational from the EX/MEM latch, in the same cycle the instruction enters MEM.
- A zero-wait `dhit` means no stall cycle. Load-to-WB latency is 1 edge after `dhit` with `mem_advance`.
- `data_stall` falls in the `dhit` cycle.
- Simultaneous `dhit` and `mem_advance`=0: data is captured into `hold_data` and no re-request is made on later cycles.
- Reset (any cycle, including mid-access):
  - state IDLE, `hold_data`=0, link invalid, `stall_cycles`=0.
  - All `wb_*` = 0.
  - Request outputs follow inputs combinationally. The cache tolerates an abandoned request.

## Configuration
- `LLSC_EN` defined:
  - The link register holds valid + address.
  - `mem_ll`+`dhit` sets link = {1, `mem_addr`}.
  - `mem_sc`: if link valid and the address matches, issue the write; on `dhit`, `wb_alu_result`=1 and the link clears. Otherwise, no cache request, no stall, `wb_alu_result`=0.
  - `ccinv` with `ccsnoopaddr`==link addr clears the link. So does any store by this core to the link address.
  - Writeback uses `WRITE_ALU` for SC.
- `LLSC_EN` undefined: `mem_ll` acts as a plain load. `mem_sc` acts as a plain store with `wb_alu_result`=1. There is no link register, and `ccinv`/`ccsnoopaddr` are ignored.

## Structure
- `cpu_types_pkg` holds:
  - `word_t`, `regbits_t`, and the `wdat_source` enum.
  - New `memstate_t` enum {IDLE, DONE}.
- Sub-module `link_reg`, instantiated only under `LLSC_EN`: set/clear/match logic.

## Test plan
- LW at 0x100, `dhit` after 3 cycles -> `data_stall`=1 for exactly 3 cycles. `wb_dmemload`=0xDEADBEEF one edge after `dhit`. `stall_cycles`=3.
- SW with `dhit` in cycle 0 -> `dmemWEN`=1 for 1 cycle, `data_stall` never 1, `wb_valid`=1 next edge.
- LW, `dhit` with `mem_advance`=0 for 4 cycles -> no re-request, `dmemload`=0x12345678 held. WB updates on the edge `mem_advance` rises.
- `LLSC_EN` on:
  - LL 0x200, then SC 0x200 -> write issued, `wb_alu_result`=1.
  - Repeat with `ccinv`, `ccsnoopaddr`=0x200 between them -> no `dmemWEN`, `wb_alu_result`=0.
- `nRST`=1 mid-stall (state DONE) -> next cycle state IDLE, all `wb_*`=0, `stall_cycles`=0.
